// File: rtl/mm_pkg.sv
// Shared definitions for the matrix multiply generator: controller state
// encoding and a helper that sizes index/address fields.
package mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } mm_state_t;

    // Width of a counter or address field covering 2^bits entries; a
    // single-entry dimension still gets one (always-zero) bit.
    function automatic int addr_w(input int bits);
        return (bits > 0) ? bits : 1;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Two-stage multiply-accumulate: operands are registered as a product one
// cycle after they are valid, and the product is summed one cycle later.
module mac_unit #(
    parameter int width     = 8,
    parameter int acc_width = 2 * width + 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clr,
    input  logic                 en,
    input  logic [width-1:0]     a,
    input  logic [width-1:0]     b,
    output logic [acc_width-1:0] acc
);

    localparam int PW = 2 * width;

    logic [PW-1:0] prod;
    logic          prod_vld;

    // Product stage; clr also flushes it so a new element starts clean.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prod     <= '0;
            prod_vld <= 1'b0;
        end else if (clr) begin
            prod     <= '0;
            prod_vld <= 1'b0;
        end else begin
            prod_vld <= en;
            if (en) begin
                prod <= PW'(a) * PW'(b);
            end
        end
    end

    // Accumulate stage; width has K_bits of headroom so it cannot wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (prod_vld) begin
            acc <= acc + acc_width'(prod);
        end
    end

endmodule

// File: rtl/matrix_multiply_gen.sv
// Sequential matrix multiply RES = A x B over external synchronous-read
// RAMs. One element at a time: K fetch cycles, 2 drain cycles for the
// read/multiply pipeline, then one write cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for Start
// FETCH | issue A[r][k] / B[k][c] reads, one k per cycle
// DRAIN | let the last reads pass through the product/accumulate stages
// WRITE | write the shifted (and optionally clamped) sum to RES[r][c]
// DONE  | one-cycle Done pulse, then back to IDLE
module matrix_multiply_gen
    import mm_pkg::*;
#(
    parameter int width    = 8,
    parameter int M_bits   = 1,
    parameter int K_bits   = 2,
    parameter int N_bits   = 0,
    parameter int SHIFT    = width,
    parameter int SATURATE = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       Start,
    output logic                       Done,
    output logic                       Busy,
    output logic                       A_read_en,
    output logic [M_bits+K_bits-1:0]   A_read_address,
    input  logic [width-1:0]           A_read_data_out,
    output logic                       B_read_en,
    output logic [K_bits+N_bits-1:0]   B_read_address,
    input  logic [width-1:0]           B_read_data_out,
    output logic                       RES_write_en,
    output logic [M_bits+N_bits-1:0]   RES_write_address,
    output logic [width-1:0]           RES_write_data_in
);

    localparam int RW    = addr_w(M_bits);
    localparam int KW    = addr_w(K_bits);
    localparam int CW    = addr_w(N_bits);
    localparam int AW    = M_bits + K_bits;
    localparam int BW    = K_bits + N_bits;
    localparam int SW    = M_bits + N_bits;
    localparam int ACC_W = 2 * width + K_bits;

    localparam logic [RW-1:0] R_LAST = RW'((1 << M_bits) - 1);
    localparam logic [KW-1:0] K_LAST = KW'((1 << K_bits) - 1);
    localparam logic [CW-1:0] C_LAST = CW'((1 << N_bits) - 1);

    mm_state_t        state;
    logic [RW-1:0]    r;
    logic [CW-1:0]    c;
    logic [KW-1:0]    k;
    logic [RW-1:0]    r_nxt;
    logic [CW-1:0]    c_nxt;
    logic             drain_2nd;
    logic             rd_vld;
    logic             last_elem;
    logic             acc_clr;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] shifted;
    logic [width-1:0] res_val;

    function automatic logic [AW-1:0] a_addr(input logic [RW-1:0] ri, input logic [KW-1:0] ki);
        return (AW'(ri) << K_bits) | AW'(ki);
    endfunction

    function automatic logic [BW-1:0] b_addr(input logic [KW-1:0] ki, input logic [CW-1:0] ci);
        return (BW'(ki) << N_bits) | BW'(ci);
    endfunction

    function automatic logic [SW-1:0] res_addr(input logic [RW-1:0] ri, input logic [CW-1:0] ci);
        return (SW'(ri) << N_bits) | SW'(ci);
    endfunction

    assign last_elem = (r == R_LAST) && (c == C_LAST);

    // Element index advance: c is the inner loop, r steps when c wraps.
    always_comb begin
        r_nxt = r;
        c_nxt = c + CW'(1);
        if (c == C_LAST) begin
            c_nxt = '0;
            r_nxt = r + RW'(1);
        end
    end

    // Accumulator clears on every entry into FETCH.
    assign acc_clr = ((state == ST_IDLE) && Start) || ((state == ST_WRITE) && !last_elem);

    // Controller with registered outputs; read addresses are loaded one
    // cycle ahead so they are on the pins during the FETCH cycle they belong to.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state             <= ST_IDLE;
            r                 <= '0;
            c                 <= '0;
            k                 <= '0;
            drain_2nd         <= 1'b0;
            Busy              <= 1'b0;
            Done              <= 1'b0;
            A_read_en         <= 1'b0;
            B_read_en         <= 1'b0;
            A_read_address    <= '0;
            B_read_address    <= '0;
            RES_write_en      <= 1'b0;
            RES_write_address <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        state          <= ST_FETCH;
                        r              <= '0;
                        c              <= '0;
                        k              <= '0;
                        Busy           <= 1'b1;
                        A_read_en      <= 1'b1;
                        B_read_en      <= 1'b1;
                        A_read_address <= '0;
                        B_read_address <= '0;
                    end
                end
                ST_FETCH: begin
                    if (k == K_LAST) begin
                        state          <= ST_DRAIN;
                        k              <= '0;
                        drain_2nd      <= 1'b0;
                        A_read_en      <= 1'b0;
                        B_read_en      <= 1'b0;
                        A_read_address <= '0;
                        B_read_address <= '0;
                    end else begin
                        k              <= k + KW'(1);
                        A_read_address <= a_addr(r, k + KW'(1));
                        B_read_address <= b_addr(k + KW'(1), c);
                    end
                end
                ST_DRAIN: begin
                    if (drain_2nd) begin
                        state             <= ST_WRITE;
                        drain_2nd         <= 1'b0;
                        RES_write_en      <= 1'b1;
                        RES_write_address <= res_addr(r, c);
                    end else begin
                        drain_2nd <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    RES_write_en      <= 1'b0;
                    RES_write_address <= '0;
                    if (last_elem) begin
                        state <= ST_DONE;
                        r     <= '0;
                        c     <= '0;
                        Done  <= 1'b1;
                    end else begin
                        state          <= ST_FETCH;
                        r              <= r_nxt;
                        c              <= c_nxt;
                        A_read_en      <= 1'b1;
                        B_read_en      <= 1'b1;
                        A_read_address <= a_addr(r_nxt, KW'(0));
                        B_read_address <= b_addr(KW'(0), c_nxt);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data returns one cycle after the enable; this bit tags it for the MAC.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= A_read_en;
        end
    end

    mac_unit #(
        .width     (width),
        .acc_width (ACC_W)
    ) u_mac (
        .clk    (clk),
        .resetn (resetn),
        .clr    (acc_clr),
        .en     (rd_vld),
        .a      (A_read_data_out),
        .b      (B_read_data_out),
        .acc    (acc)
    );

    assign shifted = acc >> SHIFT;

    // Clamp anything that does not fit in width bits, or simply truncate.
    always_comb begin
        res_val = shifted[width-1:0];
        if ((SATURATE != 0) && (|(shifted >> width))) begin
            res_val = '1;
        end
    end

    // The sum is final only during WRITE, so the data path stays combinational
    // and is held at zero outside the write strobe.
    assign RES_write_data_in = RES_write_en ? res_val : '0;

endmodule

// File: tb/tb_matrix_multiply_gen.sv
// Directed bench: default geometry (saturating and truncating), a 2x2x2
// unshifted case, a K=1 case, restart/reset behaviour and held Start.
module tb_matrix_multiply_gen;

    logic clk = 1'b0;
    logic resetn;
    logic start_d, start_s, start_k;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // default instance (d_) and truncating twin (n_) share Start and RAM contents
    logic       d_done, d_busy, d_aen, d_ben, d_wen;
    logic [2:0] d_aaddr;
    logic [1:0] d_baddr;
    logic [0:0] d_waddr;
    logic [7:0] d_adat, d_bdat, d_wdata;
    logic       n_done, n_busy, n_aen, n_ben, n_wen;
    logic [2:0] n_aaddr;
    logic [1:0] n_baddr;
    logic [0:0] n_waddr;
    logic [7:0] n_adat, n_bdat, n_wdata;
    logic [7:0] mem_a [0:7];
    logic [7:0] mem_b [0:3];

    // 2x2x2, SHIFT=0
    logic       s_done, s_busy, s_aen, s_ben, s_wen;
    logic [1:0] s_aaddr, s_baddr, s_waddr;
    logic [7:0] s_adat, s_bdat, s_wdata;
    logic [7:0] sa [0:3];
    logic [7:0] sb [0:3];

    // M=2, K=1, N=2, SHIFT=0
    logic       k_done, k_busy, k_aen, k_ben, k_wen;
    logic [0:0] k_aaddr, k_baddr;
    logic [1:0] k_waddr;
    logic [7:0] k_adat, k_bdat, k_wdata;
    logic [7:0] ka [0:1];
    logic [7:0] kb [0:1];

    matrix_multiply_gen u_def (
        .clk(clk), .resetn(resetn), .Start(start_d), .Done(d_done), .Busy(d_busy),
        .A_read_en(d_aen), .A_read_address(d_aaddr), .A_read_data_out(d_adat),
        .B_read_en(d_ben), .B_read_address(d_baddr), .B_read_data_out(d_bdat),
        .RES_write_en(d_wen), .RES_write_address(d_waddr), .RES_write_data_in(d_wdata)
    );

    matrix_multiply_gen #(.SATURATE(0)) u_ns (
        .clk(clk), .resetn(resetn), .Start(start_d), .Done(n_done), .Busy(n_busy),
        .A_read_en(n_aen), .A_read_address(n_aaddr), .A_read_data_out(n_adat),
        .B_read_en(n_ben), .B_read_address(n_baddr), .B_read_data_out(n_bdat),
        .RES_write_en(n_wen), .RES_write_address(n_waddr), .RES_write_data_in(n_wdata)
    );

    matrix_multiply_gen #(.M_bits(1), .K_bits(1), .N_bits(1), .SHIFT(0)) u_sq (
        .clk(clk), .resetn(resetn), .Start(start_s), .Done(s_done), .Busy(s_busy),
        .A_read_en(s_aen), .A_read_address(s_aaddr), .A_read_data_out(s_adat),
        .B_read_en(s_ben), .B_read_address(s_baddr), .B_read_data_out(s_bdat),
        .RES_write_en(s_wen), .RES_write_address(s_waddr), .RES_write_data_in(s_wdata)
    );

    matrix_multiply_gen #(.M_bits(1), .K_bits(0), .N_bits(1), .SHIFT(0)) u_k1 (
        .clk(clk), .resetn(resetn), .Start(start_k), .Done(k_done), .Busy(k_busy),
        .A_read_en(k_aen), .A_read_address(k_aaddr), .A_read_data_out(k_adat),
        .B_read_en(k_ben), .B_read_address(k_baddr), .B_read_data_out(k_bdat),
        .RES_write_en(k_wen), .RES_write_address(k_waddr), .RES_write_data_in(k_wdata)
    );

    // synchronous-read RAM models
    always @(posedge clk) begin
        if (d_aen) d_adat <= mem_a[d_aaddr];
        if (d_ben) d_bdat <= mem_b[d_baddr];
        if (n_aen) n_adat <= mem_a[n_aaddr];
        if (n_ben) n_bdat <= mem_b[n_baddr];
        if (s_aen) s_adat <= sa[s_aaddr];
        if (s_ben) s_bdat <= sb[s_baddr];
        if (k_aen) k_adat <= ka[k_aaddr];
        if (k_ben) k_bdat <= kb[k_baddr];
    end

    // result capture and timing monitors, sampled mid-cycle
    logic [7:0] d_res [0:1];
    logic [7:0] n_res [0:1];
    logic [7:0] s_res [0:3];
    logic [7:0] k_res [0:3];
    logic [1:0] s_log [0:15];
    int d_wr = 0, d_dn = 0, d_idx = 0, d_bs = 0;
    int n_wr = 0, n_dn = 0;
    int s_wr = 0, s_dn = 0, s_idx = 0, s_bs = 0, s_last = 0, s_gap = 0;
    int k_wr = 0, k_dn = 0, k_idx = 0, k_bs = 0;
    logic d_bq = 1'b0, s_bq = 1'b0, k_bq = 1'b0;

    always @(negedge clk) begin
        if (d_wen) begin d_res[d_waddr] = d_wdata; d_wr++; end
        if (d_done) begin d_dn++; d_idx = cyc - d_bs + 1; end
        if (d_busy && !d_bq) d_bs = cyc;
        d_bq = d_busy;
        if (n_wen) begin n_res[n_waddr] = n_wdata; n_wr++; end
        if (n_done) n_dn++;
        if (s_wen) begin s_res[s_waddr] = s_wdata; s_log[s_wr % 16] = s_waddr; s_wr++; end
        if (s_done) begin s_dn++; s_idx = cyc - s_bs + 1; s_last = cyc; end
        if (s_busy && !s_bq) begin s_bs = cyc; s_gap = cyc - s_last; end
        s_bq = s_busy;
        if (k_wen) begin k_res[k_waddr] = k_wdata; k_wr++; end
        if (k_done) begin k_dn++; k_idx = cyc - k_bs + 1; end
        if (k_busy && !k_bq) k_bs = cyc;
        k_bq = k_busy;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic fill_def(input logic [7:0] v);
        for (int i = 0; i < 8; i++) mem_a[i] = v;
        for (int i = 0; i < 4; i++) mem_b[i] = v;
        for (int i = 0; i < 2; i++) begin d_res[i] = 8'hAA; n_res[i] = 8'hAA; end
    endtask

    int base_dn, base_wr, base_nw;

    initial begin
        resetn  = 1'b0;
        start_d = 1'b0;
        start_s = 1'b0;
        start_k = 1'b0;
        fill_def(8'h00);
        sa[0] = 8'd1; sa[1] = 8'd2; sa[2] = 8'd3; sa[3] = 8'd4;
        sb[0] = 8'd5; sb[1] = 8'd6; sb[2] = 8'd7; sb[3] = 8'd8;
        ka[0] = 8'd3; ka[1] = 8'd5;
        kb[0] = 8'd7; kb[1] = 8'd9;
        for (int i = 0; i < 4; i++) begin s_res[i] = 8'hAA; k_res[i] = 8'hAA; end
        repeat (3) step();

        // reset state
        check_val("rst_busy", d_busy, 0);
        check_val("rst_done", d_done, 0);
        check_val("rst_rden", {d_aen, d_ben}, 0);
        check_val("rst_wen", d_wen, 0);
        check_val("rst_addr", {d_aaddr, d_baddr, d_waddr}, 0);
        resetn = 1'b1;
        repeat (3) step();
        check_val("idle_busy", d_busy, 0);

        // all 0xFF: saturate vs truncate
        fill_def(8'hFF);
        base_dn = d_dn; base_wr = d_wr; base_nw = n_wr;
        start_d = 1'b1; step(); start_d = 1'b0;
        repeat (25) step();
        check_val("ff_sat_res0", d_res[0], 8'hFF);
        check_val("ff_sat_res1", d_res[1], 8'hFF);
        check_val("ff_trunc_res0", n_res[0], 8'hF8);
        check_val("ff_trunc_res1", n_res[1], 8'hF8);
        check_val("ff_done_cnt", d_dn - base_dn, 1);
        check_val("ff_done_cycle", d_idx, 15);
        check_val("ff_writes", d_wr - base_wr, 2);
        check_val("ff_trunc_writes", n_wr - base_nw, 2);

        // all 0x10 with a second Start pulse in cycle 5
        fill_def(8'h10);
        base_dn = d_dn;
        start_d = 1'b1; step(); start_d = 1'b0;
        repeat (4) step();
        start_d = 1'b1; step(); start_d = 1'b0;
        repeat (25) step();
        check_val("x10_res0", d_res[0], 8'h04);
        check_val("x10_res1", d_res[1], 8'h04);
        check_val("x10_trunc_res0", n_res[0], 8'h04);
        check_val("restart_done_cnt", d_dn - base_dn, 1);
        check_val("restart_done_cycle", d_idx, 15);
        check_val("restart_busy", d_busy, 0);

        // 2x2x2 unshifted
        base_wr = s_wr;
        start_s = 1'b1; step(); start_s = 1'b0;
        repeat (30) step();
        check_val("sq_res0", s_res[0], 19);
        check_val("sq_res1", s_res[1], 22);
        check_val("sq_res2", s_res[2], 43);
        check_val("sq_res3", s_res[3], 50);
        for (int i = 0; i < 4; i++) check_val($sformatf("sq_order%0d", i), s_log[(base_wr + i) % 16], i);
        check_val("sq_done_cnt", s_dn, 1);
        check_val("sq_done_cycle", s_idx, 21);

        // K=1
        start_k = 1'b1; step(); start_k = 1'b0;
        repeat (25) step();
        check_val("k1_res0", k_res[0], 21);
        check_val("k1_res1", k_res[1], 27);
        check_val("k1_res2", k_res[2], 35);
        check_val("k1_res3", k_res[3], 45);
        check_val("k1_writes", k_wr, 4);
        check_val("k1_done_cycle", k_idx, 17);

        // reset asserted in cycle 6
        fill_def(8'h10);
        base_dn = d_dn; base_wr = d_wr;
        start_d = 1'b1; step(); start_d = 1'b0;
        repeat (5) step();
        resetn = 1'b0;
        #1;
        check_val("midrst_busy", {d_busy, n_busy}, 0);
        check_val("midrst_rden", {d_aen, d_ben}, 0);
        check_val("midrst_addr", {d_aaddr, d_baddr}, 0);
        check_val("midrst_wen_done", {d_wen, d_done}, 0);
        repeat (3) step();
        resetn = 1'b1;
        repeat (20) step();
        check_val("midrst_no_write", d_wr - base_wr, 0);
        check_val("midrst_no_done", d_dn - base_dn, 0);
        check_val("midrst_wait_start", d_busy, 0);
        check_val("midrst_res_untouched", d_res[0], 8'hAA);
        start_d = 1'b1; step(); start_d = 1'b0;
        repeat (25) step();
        check_val("postrst_res0", d_res[0], 8'h04);
        check_val("postrst_res1", d_res[1], 8'h04);
        check_val("postrst_done_cnt", d_dn - base_dn, 1);
        check_val("postrst_done_cycle", d_idx, 15);

        // Start held high: two back-to-back runs
        for (int i = 0; i < 4; i++) s_res[i] = 8'hAA;
        base_dn = s_dn; base_wr = s_wr;
        start_s = 1'b1;
        for (int i = 0; i < 100 && s_dn < base_dn + 2; i++) step();
        start_s = 1'b0;
        repeat (10) step();
        check_val("held_done_cnt", s_dn - base_dn, 2);
        check_val("held_idle_gap", s_gap, 2);
        check_val("held_done_cycle", s_idx, 21);
        check_val("held_writes", s_wr - base_wr, 8);
        check_val("held_res3", s_res[3], 50);
        check_val("held_stopped", s_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
